move_log: RTL and testbench
===========================

Name: move_log

Overview:
- Sits directly downstream of the solver top: records each move code the solver emits into a small on-chip log, then tracks the solve outcome (finished/failed).
- After a solve completes, the recorded sequence is available two ways: random access from the register interface, or an in-order stream through a valid/ready port to the move display/transmit logic.

Parameters:
CODE_W, 4, width of one move code (matches solver step output)
DEPTH, 16, log capacity in entries (power of two)
MAX_MOVES, 10, moves accepted before overflow is declared (MAX_MOVES <= DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  pulse: clear log, enter LOG
mv_valid  in  1  one-cycle strobe: mv_code is a new move
mv_code  in  CODE_W  move code to record
fin  in  1  solver finished (level; solver q)
rd_en  in  1  random-access read request
rd_addr  in  clog2(DEPTH)  entry index to read
rd_data  out  CODE_W  read data, registered
rd_valid  out  1  rd_data valid (1 cycle after rd_en)
rd_err  out  1  with rd_valid: rd_addr >= count
play  in  1  pulse: start in-order stream of the log
out_valid  out  1  stream data valid
out_ready  in  1  stream consumer ready
out_code  out  CODE_W  stream data
out_last  out  1  marks final streamed entry
count  out  clog2(DEPTH)+1  entries recorded
busy  out  1  state is LOG or PLAY
done  out  1  state is DONE
fail  out  1  state is FAIL

Behaviour:
- Reset: state IDLE; count=0, wr_ptr=0, rd_ptr=0; rd_data=0, rd_valid=0, rd_err=0, out_valid=0, out_code=0, out_last=0. Memory contents are not reset. Reset mid-operation aborts immediately.
- States: IDLE, LOG, DONE, FAIL, PLAY.
- start (any state, highest priority): count<=0, wr_ptr<=0, out_valid<=0, next state LOG. A start in the same cycle as mv_valid discards the move.
- LOG:
  - mv_valid with count<MAX_MOVES: mem[wr_ptr]<=mv_code, wr_ptr++, count++.
  - mv_valid with count==MAX_MOVES: nothing written, next state FAIL.
  - fin=1: next state DONE. If mv_valid occurs in the same cycle with room, the move is written first, then DONE. If mv_valid occurs in the same cycle with no room, next state is FAIL (FAIL wins).
  - fin with count==0 is legal: DONE with an empty log.
- mv_valid outside LOG is ignored. fin outside LOG is ignored.
- DONE: play and count>0 -> PLAY, rd_ptr<=0. play and count==0 -> stay in DONE, no output.
- FAIL: the log stays readable and play is ignored. Only start or reset leaves FAIL.
- PLAY (AXI-style handshake):
  - out_valid rises the cycle after entry, with out_code=mem[0].
  - Transfer occurs when out_valid and out_ready are both 1. On transfer rd_ptr++ and the next entry is presented the following cycle. No bubble is required but one is allowed; throughput must be at least 1 entry per 2 cycles.
  - out_code/out_last must remain stable while out_valid=1 and out_ready=0.
  - out_last=1 when rd_ptr==count-1. Transfer of the last entry -> out_valid<=0, next state DONE (replay allowed).
  - play while in PLAY is ignored.
- Random-access read: legal in every state and independent of the FSM.
  - rd_en -> next cycle rd_valid=1 and rd_data=mem[rd_addr].
  - If rd_addr>=count: rd_data=0 and rd_err=1.
  - A read of an entry written in the same cycle returns the new value (write-first).
- count saturates at MAX_MOVES; wr_ptr never wraps past MAX_MOVES.
- busy/done/fail are decoded combinationally from the state register; exactly one of busy/done/fail/IDLE holds.

Test Plan:
- Reset, start, then 3 mv_valid pulses with codes 3,7,A, then fin -> count=3, done=1; rd_addr=1 returns 7 with rd_valid one cycle after rd_en; rd_addr=3 returns rd_err=1, rd_data=0.
- Log codes 1..A (10 moves), then an 11th mv_valid -> fail=1, count=10, entry 10 unwritten; play is ignored (out_valid stays 0); start returns to LOG with count=0.
- mv_valid (code 5) in the same cycle as fin with count=2 -> count=3, entry 2=5, done=1. Repeat at count=10 -> fail=1.
- After logging 4,2,9: play with out_ready held 0 for 3 cycles -> out_code=4 stable and out_valid=1. Then out_ready=1 continuously -> 4,2,9 emitted, out_last only on 9, returns to DONE. A second play repeats the sequence.
- fin with no moves logged -> done=1, count=0; play -> no out_valid, stays DONE.
- Assert rst_n low mid-PLAY (after 1 transfer) -> out_valid=0 and state IDLE immediately (asynchronous), count=0 after release.

Source files
------------

// File: rtl/move_log.sv
// rtl/move_log.sv - move recorder for the solver: logs move codes, tracks the
// solve outcome and replays the log by random-access reads or an in-order stream.
module move_log #(
  parameter int CODE_W    = 4,
  parameter int DEPTH     = 16,
  parameter int MAX_MOVES = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       mv_valid,
  input  logic [CODE_W-1:0]          mv_code,
  input  logic                       fin,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [CODE_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       rd_err,
  input  logic                       play,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CODE_W-1:0]          out_code,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       done,
  output logic                       fail
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_MOVES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOG,
    S_DONE,
    S_FAIL,
    S_PLAY
  } state_t;

  state_t state, state_d;

  logic [CODE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     nxt_ptr;
  logic [CW-1:0]     last_idx;
  logic [CW-1:0]     count_eff;
  logic              room;
  logic              wr_en;
  logic              xfer;
  logic              play_go;

  assign room      = (count < MAX_CNT);
  assign wr_en     = !start && (state == S_LOG) && mv_valid && room;
  assign xfer      = (state == S_PLAY) && out_valid && out_ready;
  assign play_go   = !start && (state == S_DONE) && play && (count != '0);
  assign nxt_ptr   = rd_ptr + AW'(1);
  assign last_idx  = count - CW'(1);
  // A read racing a write to the same entry sees the entry as already present.
  assign count_eff = count + CW'(wr_en);

  assign busy = (state == S_LOG) || (state == S_PLAY);
  assign done = (state == S_DONE);
  assign fail = (state == S_FAIL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    if (start) begin
      state_d = S_LOG;
    end else begin
      case (state)
        S_LOG: begin
          // Overflow outranks a simultaneous finish.
          if (mv_valid && !room) begin
            state_d = S_FAIL;
          end else if (fin) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (play_go) begin
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (xfer && out_last) begin
            state_d = S_DONE;
          end
        end
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= mv_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_last  <= 1'b0;
    end else if (start) begin
      count     <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CW'(1);
      end
      if (play_go) begin
        rd_ptr    <= '0;
        out_valid <= 1'b0;
      end else if (state == S_PLAY) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_code  <= mem[rd_ptr];
          out_last  <= ({1'b0, rd_ptr} == last_idx);
        end else if (xfer) begin
          if (out_last) begin
            out_valid <= 1'b0;
          end else begin
            // Present the following entry back-to-back, no bubble.
            rd_ptr   <= nxt_ptr;
            out_code <= mem[nxt_ptr];
            out_last <= ({1'b0, nxt_ptr} == last_idx);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if ({1'b0, rd_addr} >= count_eff) begin
          rd_err  <= 1'b1;
          rd_data <= '0;
        end else begin
          rd_err  <= 1'b0;
          rd_data <= (wr_en && (rd_addr == wr_ptr)) ? mv_code : mem[rd_addr];
        end
      end else begin
        rd_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_move_log.sv
// tb/tb_move_log.sv - randomized self-checking bench for move_log against a
// queue-based model of the log and its solve outcome.
module tb_move_log;

  localparam int CODE_W    = 4;
  localparam int DEPTH     = 16;
  localparam int MAX_MOVES = 10;
  localparam int AW        = 4;
  localparam int CW        = 5;

  localparam int M_IDLE = 0;
  localparam int M_LOG  = 1;
  localparam int M_DONE = 2;
  localparam int M_FAIL = 3;
  localparam int M_PLAY = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mv_valid = 1'b0;
  logic [CODE_W-1:0] mv_code = '0;
  logic              fin = 1'b0;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic [CODE_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic              play = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CODE_W-1:0] out_code;
  logic              out_last;
  logic [CW-1:0]     count;
  logic              busy;
  logic              done;
  logic              fail;

  move_log #(.CODE_W(CODE_W), .DEPTH(DEPTH), .MAX_MOVES(MAX_MOVES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mv_valid(mv_valid),
    .mv_code(mv_code), .fin(fin), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err), .play(play),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_last(out_last), .count(count), .busy(busy), .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CODE_W-1:0] q[$];
  int mode = M_IDLE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), 32'(q.size()));
    check({tag, "_busy"}, 32'(busy), 32'(mode == M_LOG || mode == M_PLAY));
    check({tag, "_done"}, 32'(done), 32'(mode == M_DONE));
    check({tag, "_fail"}, 32'(fail), 32'(mode == M_FAIL));
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    q.delete();
    mode = M_LOG;
    check_status("start");
  endtask

  task automatic drive(input bit mvv, input logic [CODE_W-1:0] code, input bit finv,
                       input bit rdv, input int addr);
    bit exp_err;
    mv_valid = mvv; mv_code = code; fin = finv; rd_en = rdv; rd_addr = AW'(addr);
    step();
    mv_valid = 1'b0; fin = 1'b0; rd_en = 1'b0;
    if (mode == M_LOG) begin
      if (mvv) begin
        if (q.size() < MAX_MOVES) q.push_back(code);
        else mode = M_FAIL;
      end
      if (mode == M_LOG && finv) mode = M_DONE;
    end
    if (rdv) begin
      exp_err = (addr >= q.size());
      check("rd_valid", 32'(rd_valid), 32'd1);
      check("rd_err", 32'(rd_err), 32'(exp_err));
      check("rd_data", 32'(rd_data), exp_err ? 32'd0 : 32'(q[addr]));
    end
    check_status("drive");
  endtask

  task automatic play_stream(input int ready_pct, input bit hold_first);
    int n;
    int idx;
    int cyc;
    bit prev_stall;
    logic [CODE_W-1:0] prev_code;
    logic prev_last;
    play = 1'b1;
    step();
    play = 1'b0;
    n = q.size();
    if (!(mode == M_DONE && n > 0)) begin
      repeat (4) begin
        check("no_stream_valid", 32'(out_valid), 32'd0);
        step();
      end
      check_status("play_ignored");
      return;
    end
    mode = M_PLAY;
    check_status("play_entry");
    idx = 0; cyc = 0; prev_stall = 1'b0; prev_code = '0; prev_last = 1'b0;
    if (hold_first) begin
      out_ready = 1'b0;
      while (!out_valid && cyc < 10) begin
        step();
        cyc++;
      end
      check("first_valid", 32'(out_valid), 32'd1);
      repeat (3) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_code", 32'(out_code), 32'(q[0]));
        step();
        cyc++;
      end
    end
    while (idx < n && cyc < 400) begin
      out_ready = ($urandom_range(99) < ready_pct);
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_code", 32'(out_code), 32'(prev_code));
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        check("stream_code", 32'(out_code), 32'(q[idx]));
        check("stream_last", 32'(out_last), 32'(idx == n - 1));
        idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_code = out_code;
      prev_last = out_last;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    check("stream_len", 32'(idx), 32'(n));
    if (ready_pct == 100 && !hold_first)
      check("stream_rate", 32'(cyc <= 2 * n + 2), 32'd1);
    mode = M_DONE;
    check("stream_end_valid", 32'(out_valid), 32'd0);
    check_status("stream_end");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_out_code", 32'(out_code), 32'd0);
    rst_n = 1'b1;
    step();
    check_status("idle");

    // Basic log of 3,7,A then reads.
    do_start();
    drive(1, 4'h3, 0, 0, 0);
    drive(1, 4'h7, 0, 0, 0);
    drive(1, 4'hA, 0, 0, 0);
    drive(0, 4'h0, 1, 0, 0);
    drive(0, 4'h0, 0, 1, 1);
    step();
    check("rd_valid_drop", 32'(rd_valid), 32'd0);
    drive(0, 4'h0, 0, 1, 3);

    // Overflow: 10 moves then an 11th.
    do_start();
    for (int i = 1; i <= 10; i++) drive(1, CODE_W'(i), 0, 0, 0);
    drive(1, 4'hF, 0, 0, 0);
    drive(0, 4'h0, 0, 1, 10);
    drive(0, 4'h0, 0, 1, 9);
    play_stream(100, 0);
    do_start();

    // Move plus finish in one cycle, with and without room; write-first read.
    drive(1, 4'h1, 0, 0, 0);
    drive(1, 4'h2, 0, 1, 1);
    drive(1, 4'h5, 1, 0, 0);
    drive(0, 4'h0, 0, 1, 2);
    do_start();
    for (int i = 0; i < 10; i++) drive(1, CODE_W'($urandom), 0, 0, 0);
    drive(1, 4'h6, 1, 0, 0);

    // Stream 4,2,9 with initial stall, then replay.
    do_start();
    drive(1, 4'h4, 0, 0, 0);
    drive(1, 4'h2, 0, 0, 0);
    drive(1, 4'h9, 0, 0, 0);
    drive(0, 4'h0, 1, 0, 0);
    play_stream(100, 1);
    play_stream(100, 0);
    play_stream(50, 0);

    // Empty log.
    do_start();
    drive(0, 4'h0, 1, 0, 0);
    play_stream(100, 0);

    // Randomized sessions.
    for (int it = 0; it < 12; it++) begin
      int n;
      do_start();
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(3) == 0) drive(0, 4'h0, 0, $urandom_range(1), $urandom_range(15));
        drive(1, CODE_W'($urandom), 0, $urandom_range(1), $urandom_range(15));
      end
      drive($urandom_range(1), CODE_W'($urandom), 1, $urandom_range(1), $urandom_range(15));
      for (int i = 0; i < 3; i++) drive(0, 4'h0, $urandom_range(1), 1, $urandom_range(15));
      play_stream($urandom_range(30, 100), 0);
      drive(1, CODE_W'($urandom), 1, 1, $urandom_range(15));
      play_stream(100, 0);
    end

    // Asynchronous reset in the middle of a stream.
    do_start();
    for (int i = 0; i < 4; i++) drive(1, CODE_W'(i + 8), 0, 0, 0);
    drive(0, 4'h0, 1, 0, 0);
    play = 1'b1;
    step();
    play = 1'b0;
    out_ready = 1'b1;
    begin
      int cyc = 0;
      while (!out_valid && cyc < 10) begin
        step();
        cyc++;
      end
    end
    check("mid_valid", 32'(out_valid), 32'd1);
    check("mid_code0", 32'(out_code), 32'h8);
    step();
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_fail", 32'(fail), 32'd0);
    out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    q.delete();
    mode = M_IDLE;
    step();
    check_status("after_reset");
    check("after_reset_out_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
